// File: rtl/evm_booth_arbiter.sv
// Round-robin arbiter that shares one voter database and candidate tally between voting booths.
// Define TALLY_SAT_EN to make tallies saturate instead of wrapping.
module evm_booth_arbiter #(
  parameter int unsigned NUM_BOOTHS = 4,
  parameter int unsigned NUM_VOTERS = 8,
  parameter int unsigned ID_W       = 3,
  parameter int unsigned NUM_CAND   = 4,
  parameter int unsigned CNT_W      = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         election_open,
  input  logic [NUM_BOOTHS-1:0]        req,
  input  logic [NUM_BOOTHS*ID_W-1:0]   req_id,
  input  logic [NUM_BOOTHS*2-1:0]      req_option,
  output logic [NUM_BOOTHS-1:0]        grant,
  output logic                         done,
  output logic                         accepted,
  output logic                         rejected,
  output logic                         busy,
  output logic [NUM_CAND*CNT_W-1:0]    tally
);

  localparam int unsigned BW = (NUM_BOOTHS > 1) ? $clog2(NUM_BOOTHS) : 1;

  typedef enum logic [1:0] {StArb, StCheck, StResp} state_e;

  state_e           state;
  logic [BW-1:0]    rr;
  logic [ID_W-1:0]  id_q;
  logic [1:0]       opt_q;
  logic [NUM_VOTERS-1:0] voted;
  logic [CNT_W-1:0] count [NUM_CAND];

  logic             found;
  logic [BW-1:0]    win;
  int unsigned      idx;

  // First pending request at or after the rr pointer, wrapping.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int i = 0; i < NUM_BOOTHS; i++) begin
      idx = (32'(rr) + 32'(i)) % NUM_BOOTHS;
      if (!found && req[BW'(idx)]) begin
        found = 1'b1;
        win   = BW'(idx);
      end
    end
  end

  logic id_bad, opt_bad, vote_ok;

  always_comb begin
    id_bad  = 32'(id_q) >= NUM_VOTERS;
    opt_bad = 32'(opt_q) >= NUM_CAND;
    vote_ok = !id_bad && !opt_bad && !voted[id_q];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= StArb;
      rr       <= '0;
      id_q     <= '0;
      opt_q    <= '0;
      voted    <= '0;
      grant    <= '0;
      done     <= 1'b0;
      accepted <= 1'b0;
      rejected <= 1'b0;
      busy     <= 1'b0;
      for (int c = 0; c < NUM_CAND; c++) count[c] <= '0;
    end else begin
      unique case (state)
        StArb: begin
          if (election_open && found) begin
            id_q  <= req_id[32'(win)*ID_W +: ID_W];
            opt_q <= req_option[32'(win)*2 +: 2];
            grant <= {{(NUM_BOOTHS-1){1'b0}}, 1'b1} << win;
            busy  <= 1'b1;
            rr    <= (32'(win) == NUM_BOOTHS - 1) ? '0 : win + 1'b1;
            state <= StCheck;
          end else begin
            grant <= '0;
            busy  <= 1'b0;
          end
        end
        StCheck: begin
          if (vote_ok) begin
            voted[id_q] <= 1'b1;
`ifdef TALLY_SAT_EN
            if (count[opt_q] != '1) count[opt_q] <= count[opt_q] + 1'b1;
`else
            count[opt_q] <= count[opt_q] + 1'b1;
`endif
          end
          done     <= 1'b1;
          accepted <= vote_ok;
          rejected <= !vote_ok;
          state    <= StResp;
        end
        StResp: begin
          done     <= 1'b0;
          accepted <= 1'b0;
          rejected <= 1'b0;
          grant    <= '0;
          busy     <= 1'b0;
          state    <= StArb;
        end
        default: state <= StArb;
      endcase
    end
  end

  for (genvar c = 0; c < NUM_CAND; c++) begin : g_tally
    assign tally[c*CNT_W +: CNT_W] = count[c];
  end

endmodule
